// File: rtl/exu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide.
// Optional macro EXU_MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module exu_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_data_i,
    input  logic [XLEN-1:0] op2_data_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            stallreq_o
);
    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd3;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        op_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic              neg;
    logic [XLEN-1:0]   result_q;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] sign_fix(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Start-cycle decode: operand magnitudes, result sign and single-cycle special cases
    logic            accept, signed1, signed2, sign1, sign2, neg_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

`ifdef EXU_MULDIV_FAST_MUL_EN
    localparam int PW = 2*XLEN+2;
    logic signed [XLEN:0] fast_a, fast_b;
    logic signed [PW-1:0] fast_prod;
    assign fast_a    = {sign1, op1_data_i};
    assign fast_b    = {sign2, op2_data_i};
    assign fast_prod = PW'(fast_a) * PW'(fast_b);
`endif

    assign accept = (state == IDLE) & start_i & ~flush_i;

    always_comb begin
        signed1  = op_i[2] ? ~op_i[0] : (op_i != OP_MULHU);
        signed2  = op_i[2] ? ~op_i[0] : (op_i[1:0] < 2'd2);
        sign1    = signed1 & op1_data_i[XLEN-1];
        sign2    = signed2 & op2_data_i[XLEN-1];
        mag1     = magnitude(op1_data_i, sign1);
        mag2     = magnitude(op2_data_i, sign2);
        // REM/REMU take the dividend sign; everything else the product/quotient sign
        neg_in   = (op_i[2] & op_i[1]) ? sign1 : (sign1 ^ sign2);
        div_zero = op_i[2] & (op2_data_i == '0);
        div_ovf  = op_i[2] & ~op_i[0] & (op1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_data_i);
        special     = div_zero | div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? op1_data_i : '1;
        else if (div_ovf)
            special_res = op_i[1] ? '0 : op1_data_i;
`ifdef EXU_MULDIV_FAST_MUL_EN
        if (~op_i[2]) begin
            special     = 1'b1;
            special_res = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Iteration step: shift-add multiply or restoring divide, plus final sign correction
    logic [XLEN:0]     mul_sum, rem_nxt;
    logic [XLEN+1:0]   rem_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] acc_nxt, raw, fixed;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        rem_diff = {rem, acc[XLEN-1]} - {2'b00, mcand};
        q_bit    = ~rem_diff[XLEN+1];
        rem_nxt  = q_bit ? rem_diff[XLEN:0] : {rem[XLEN-1:0], acc[XLEN-1]};
        if (op_q[2])
            acc_nxt = {{XLEN{1'b0}}, acc[XLEN-2:0], q_bit};
        else
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        if (op_q[2] & op_q[1])
            raw = {{XLEN{1'b0}}, rem_nxt[XLEN-1:0]};
        else
            raw = acc_nxt;
        fixed   = sign_fix(raw, neg);
        fin_res = (~op_q[2] & (op_q != OP_MUL)) ? fixed[2*XLEN-1:XLEN] : fixed[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            cnt      <= '0;
            mcand    <= '0;
            acc      <= '0;
            rem      <= '0;
            neg      <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= op_i;
            neg      <= neg_in;
            cnt      <= CNT_W'(XLEN-1);
            mcand    <= op_i[2] ? mag2 : mag1;
            acc      <= {{XLEN{1'b0}}, (op_i[2] ? mag1 : mag2)};
            rem      <= '0;
            result_q <= special_res;
        end else if (state == CALC) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_nxt;
            rem <= rem_nxt;
            if (cnt == '0)
                result_q <= fin_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        stallreq_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        result_o   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stallreq_o = 1'b1;
                    state_nxt  = special ? DONE : CALC;
                end
            end
            CALC: begin
                stallreq_o = 1'b1;
                busy_o     = 1'b1;
                if (cnt == '0)
                    state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                result_o  = result_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i)
            state_nxt = IDLE;
    end
endmodule

// File: tb/tb_exu_muldiv.sv
// Self-checking bench for exu_muldiv: directed cases, random ops against an arithmetic model,
// flush and asynchronous reset. Honours EXU_MULDIV_FAST_MUL_EN for multiply latency.
module tb_exu_muldiv;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      op = 3'd0;
    logic [XLEN-1:0] op1 = '0;
    logic [XLEN-1:0] op2 = '0;
    logic [XLEN-1:0] result;
    logic            done, busy, stallreq;

    int n_cmp = 0;
    int n_bad = 0;

    exu_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op),
        .op1_data_i(op1), .op2_data_i(op2), .flush_i(flush),
        .result_o(result), .done_o(done), .busy_o(busy), .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 1;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
`ifdef EXU_MULDIV_FAST_MUL_EN
        return 1;
`else
        return XLEN + 1;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called one time unit after a rising edge with the DUT idle; that cycle is cycle 0.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int  lat;
        bit  seen;
        lat   = exp_lat(f, a, b);
        start = 1'b1; op = f; op1 = a; op2 = b;
        @(negedge clk);
        chk1("stall_c0", stallreq, 1'b1);
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("done_cycle", 32'(cyc), 32'(lat));
                chk("result", result, exp);
                chk1("stall_done", stallreq, 1'b0);
                chk1("busy_done", busy, 1'b0);
            end else begin
                chk1("stall_calc", stallreq, 1'b1);
                chk1("busy_calc", busy, 1'b1);
            end
            @(posedge clk); #1;
        end
        if (!seen) chk1("done_timeout", 1'b0, 1'b1);
        @(negedge clk);
        chk1("done_after", done, 1'b0);
        chk("result_idle", result, 32'h0);
        @(posedge clk); #1;
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                32'd2, 32'd7, 32'd7, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};

    initial begin
        int spurious;
        logic [2:0]  f;
        logic [31:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        chk1("rst_done", done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_stall", stallreq, 1'b0);
        chk("rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_op(d_op[i], d_a[i], d_b[i], d_exp[i]);

        start = 1'b1; op = 3'd5; op1 = $urandom; op2 = $urandom | 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk1("flush_pre_done", done, 1'b0);
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk1("flush_c10_busy", busy, 1'b1);
        chk1("flush_c10_done", done, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk1("flush_c11_busy", busy, 1'b0);
        chk1("flush_c11_stall", stallreq, 1'b0);
        chk1("flush_c11_done", done, 1'b0);
        @(posedge clk); #1;
        run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);

        start = 1'b1; flush = 1'b1; op = 3'd5; op1 = 32'd50; op2 = 32'd5;
        @(negedge clk);
        chk1("flush_start_stall", stallreq, 1'b0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk1("flush_start_busy", busy, 1'b0);
        chk1("flush_start_done", done, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, ref_model(f, a, b));
        end

        start = 1'b1; op = 3'd4; op1 = $urandom; op2 = $urandom | 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_busy", busy, 1'b0);
        chk1("async_rst_done", done, 1'b0);
        chk1("async_rst_stall", stallreq, 1'b0);
        chk("async_rst_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || stallreq || result != 0) spurious++;
        end
        chk("no_spurious", 32'(spurious), 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            run_op(f, a, b, ref_model(f, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
